// File: rtl/rec_ctrl.sv
// Recording controller: buffers ADC samples in a small FIFO and streams them
// to consecutive SRAM words over a req/ack handshake under start/pause/stop control.
module rec_ctrl #(
    parameter int unsigned       ADDR_W     = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR   = {ADDR_W{1'b1}},
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              clk_p,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic [15:0]       in_data,
    input  logic              in_en,
    output logic              sram_req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic              sram_ack,
    output logic [ADDR_W:0]   rec_len,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_PAUSE,
        S_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              req_q, req_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [15:0]       mem_q [FIFO_DEPTH];

    logic              pop;
    logic              push_try;
    logic              push;
    logic              fifo_full;
    logic              mem_full;

    // State and datapath registers
    always_ff @(posedge clk_p or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk_p) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Next-state, FIFO bookkeeping and handshake
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        pop       = req_q && sram_ack;
        push_try  = in_en && (state_q == S_REC);
        fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
        mem_full  = pop && (addr_q == MAX_ADDR);
        push      = push_try && (!fifo_full || pop) && !mem_full;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    state_d  = S_REC;
                    addr_d   = '0;
                    len_d    = '0;
                    ovf_d    = 1'b0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end
            end
            S_REC: begin
                if (cmd_stop) begin
                    state_d = S_FLUSH;
                end else if (cmd_pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (cmd_stop) begin
                    state_d = S_FLUSH;
                end else if (cmd_start) begin
                    state_d = S_REC;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            len_d    = len_q + LEN_W'(1);
            if (addr_q != MAX_ADDR) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (push_try && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        // Last word written: queued samples have nowhere to go, discard them
        if (mem_full) begin
            state_d  = S_FLUSH;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end

        req_d   = (cnt_d != '0);
        wdata_d = (push && (wr_ptr_q == rd_ptr_d)) ? in_data : mem_q[rd_ptr_d];
        busy_d  = (state_d != S_IDLE);
    end

    assign sram_req   = req_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign rec_len    = len_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_rec_ctrl.sv
// Directed self-checking bench for rec_ctrl; a second instance with MAX_ADDR=3
// covers the memory-full path.
module tb_rec_ctrl;

    logic        clk_p = 1'b0;
    logic        rst;
    logic        cmd_start, cmd_pause, cmd_stop;
    logic [15:0] in_data;
    logic        in_en;
    logic        sram_ack;
    logic        sram_req;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [20:0] rec_len;
    logic        busy, done, overflow;

    logic        start_s, ack_s;
    logic        req_s;
    logic [19:0] addr_s;
    logic [15:0] wdata_s;
    logic [20:0] len_s;
    logic        busy_s, done_s, ovf_s;

    int          n_vec = 0;
    int          n_err = 0;

    int          ack_mode  = 0;  // 0: low, 1: always high, 2: one cycle after req
    logic        ack_force = 1'b0;

    logic [19:0] wa [0:63];
    logic [15:0] wd [0:63];
    int          nw = 0;
    int          done_cnt = 0;
    logic [19:0] wa_s [0:15];
    logic [15:0] wd_s [0:15];
    int          nw_s = 0;
    int          done_cnt_s = 0;

    always #5 clk_p = ~clk_p;

    rec_ctrl u_dut (
        .clk_p      (clk_p),
        .rst        (rst),
        .cmd_start  (cmd_start),
        .cmd_pause  (cmd_pause),
        .cmd_stop   (cmd_stop),
        .in_data    (in_data),
        .in_en      (in_en),
        .sram_req   (sram_req),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_ack   (sram_ack),
        .rec_len    (rec_len),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    rec_ctrl #(.ADDR_W(20), .MAX_ADDR(20'd3), .FIFO_DEPTH(4)) u_dut_small (
        .clk_p      (clk_p),
        .rst        (rst),
        .cmd_start  (start_s),
        .cmd_pause  (cmd_pause),
        .cmd_stop   (cmd_stop),
        .in_data    (in_data),
        .in_en      (in_en),
        .sram_req   (req_s),
        .sram_addr  (addr_s),
        .sram_wdata (wdata_s),
        .sram_ack   (ack_s),
        .rec_len    (len_s),
        .busy       (busy_s),
        .done       (done_s),
        .overflow   (ovf_s)
    );

    // SRAM responder for the main instance
    always @(posedge clk_p) begin
        #2;
        case (ack_mode)
            1:       sram_ack = 1'b1;
            2:       sram_ack = (sram_req && !sram_ack) || ack_force;
            default: sram_ack = ack_force;
        endcase
    end

    // Write and done monitors, sampled mid-cycle
    always @(negedge clk_p) begin
        if (sram_req && sram_ack) begin
            if (nw < 64) begin
                wa[nw] <= sram_addr;
                wd[nw] <= sram_wdata;
            end
            nw <= nw + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (req_s && ack_s) begin
            if (nw_s < 16) begin
                wa_s[nw_s] <= addr_s;
                wd_s[nw_s] <= wdata_s;
            end
            nw_s <= nw_s + 1;
        end
        if (done_s) done_cnt_s <= done_cnt_s + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_cmd(input logic s, input logic p, input logic t);
        cmd_start = s;
        cmd_pause = p;
        cmd_stop  = t;
        tick();
        cmd_start = 1'b0;
        cmd_pause = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] d);
        in_en   = 1'b1;
        in_data = d;
        tick();
        in_en   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(done), 32'd1);
        ticks(2);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [19:0] a, input logic [15:0] d);
        check_eq({tag, "_addr"}, 32'(wa[idx]), 32'(a));
        check_eq({tag, "_data"}, 32'(wd[idx]), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        logic [15:0] t1 [3];
        t1[0] = 16'h1111;
        t1[1] = 16'h2222;
        t1[2] = 16'h3333;

        rst = 1'b0;
        cmd_start = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
        in_data = '0; in_en = 1'b0;
        start_s = 1'b0; ack_s = 1'b0;
        ticks(3);
        check_eq("rst_req",   32'(sram_req),   32'd0);
        check_eq("rst_addr",  32'(sram_addr),  32'd0);
        check_eq("rst_wdata", 32'(sram_wdata), 32'd0);
        check_eq("rst_len",   32'(rec_len),    32'd0);
        check_eq("rst_busy",  32'(busy),       32'd0);
        check_eq("rst_done",  32'(done),       32'd0);
        check_eq("rst_ovf",   32'(overflow),   32'd0);
        rst = 1'b1;
        ticks(2);

        // 1: three spaced samples, ack one cycle after each request
        ack_mode = 2;
        base = nw; dbase = done_cnt;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        check_eq("t1_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            strobe(t1[i]);
            check_eq("t1_req",   32'(sram_req),   32'd1);
            check_eq("t1_wdata", 32'(sram_wdata), 32'(t1[i]));
            check_eq("t1_addr",  32'(sram_addr),  32'(i));
            ticks(7);
            check_eq("t1_len", 32'(rec_len), 32'(i + 1));
        end
        pulse_cmd(1'b0, 1'b0, 1'b1);
        check_eq("t1_done_early", 32'(done), 32'd0);
        check_eq("t1_busy_flush", 32'(busy), 32'd1);
        tick();
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_busy_fall", 32'(busy), 32'd0);
        tick();
        check_eq("t1_done_pulse", 32'(done), 32'd0);
        check_eq("t1_done_cnt", 32'(done_cnt - dbase), 32'd1);
        check_eq("t1_nw", 32'(nw - base), 32'd3);
        for (int i = 0; i < 3; i++) check_wr("t1_wr", base + i, 20'(i), t1[i]);
        check_eq("t1_len_final", 32'(rec_len), 32'd3);

        // 2: overflow with ack held low, then drain
        ack_mode = 0;
        base = nw;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        check_eq("t2_len_clr", 32'(rec_len), 32'd0);
        for (int i = 0; i < 6; i++) begin
            in_en = 1'b1;
            in_data = 16'hA000 + 16'(i);
            tick();
        end
        in_en = 1'b0;
        check_eq("t2_ovf",   32'(overflow),   32'd1);
        check_eq("t2_req",   32'(sram_req),   32'd1);
        check_eq("t2_wdata", 32'(sram_wdata), 32'hA000);
        ack_mode = 1;
        ticks(6);
        check_eq("t2_nw", 32'(nw - base), 32'd4);
        for (int i = 0; i < 4; i++) check_wr("t2_wr", base + i, 20'(i), 16'hA000 + 16'(i));
        check_eq("t2_len", 32'(rec_len), 32'd4);
        check_eq("t2_req_idle", 32'(sram_req), 32'd0);
        pulse_cmd(1'b0, 1'b0, 1'b1);
        wait_done("t2_done", 20);
        check_eq("t2_ovf_sticky", 32'(overflow), 32'd1);

        // 3: pause drops strobes, resume continues the address
        ack_mode = 2;
        base = nw;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        check_eq("t3_ovf_clr", 32'(overflow), 32'd0);
        strobe(16'h0A0A);
        ticks(3);
        pulse_cmd(1'b0, 1'b1, 1'b0);
        check_eq("t3_busy_pause", 32'(busy), 32'd1);
        strobe(16'hBAD1);
        strobe(16'hBAD2);
        check_eq("t3_req_pause", 32'(sram_req), 32'd0);
        pulse_cmd(1'b1, 1'b0, 1'b0);
        strobe(16'h0B0B);
        check_eq("t3_addr_resume", 32'(sram_addr), 32'd1);
        check_eq("t3_wdata_b", 32'(sram_wdata), 32'h0B0B);
        ticks(3);
        pulse_cmd(1'b0, 1'b0, 1'b1);
        wait_done("t3_done", 20);
        check_eq("t3_nw", 32'(nw - base), 32'd2);
        check_wr("t3_wr_a", base, 20'd0, 16'h0A0A);
        check_wr("t3_wr_b", base + 1, 20'd1, 16'h0B0B);
        check_eq("t3_ovf", 32'(overflow), 32'd0);
        check_eq("t3_len", 32'(rec_len), 32'd2);

        // 4: memory full on the MAX_ADDR=3 instance
        ack_s = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_en = 1'b1;
            in_data = 16'hC000 + 16'(i);
            tick();
        end
        in_en = 1'b0;
        ticks(2);
        check_eq("t4_nw", 32'(nw_s), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_wr_addr", 32'(wa_s[i]), 32'(i));
            check_eq("t4_wr_data", 32'(wd_s[i]), 32'(16'hC000 + 16'(i)));
        end
        check_eq("t4_done_cnt", 32'(done_cnt_s), 32'd1);
        check_eq("t4_len",  32'(len_s),  32'd4);
        check_eq("t4_ovf",  32'(ovf_s),  32'd0);
        check_eq("t4_busy", 32'(busy_s), 32'd0);
        check_eq("t4_addr", 32'(addr_s), 32'd3);
        ack_s = 1'b0;

        // 5: stray ack, then stop+pause+start together
        ack_mode = 0;
        base = nw; dbase = done_cnt;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        tick();
        check_eq("t5_addr_stray", 32'(sram_addr), 32'd0);
        check_eq("t5_len_stray",  32'(rec_len),   32'd0);
        strobe(16'h5555);
        pulse_cmd(1'b1, 1'b1, 1'b1);
        check_eq("t5_busy", 32'(busy), 32'd1);
        strobe(16'h5A5A);
        ack_mode = 1;
        wait_done("t5_done", 20);
        check_eq("t5_done_cnt", 32'(done_cnt - dbase), 32'd1);
        check_eq("t5_nw", 32'(nw - base), 32'd1);
        check_wr("t5_wr", base, 20'd0, 16'h5555);

        // 6: async reset with a request pending
        ack_mode = 2;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        strobe(16'h6161);
        ticks(3);
        ack_mode = 0;
        strobe(16'h6262);
        check_eq("t6_req_pend", 32'(sram_req), 32'd1);
        check_eq("t6_addr_pend", 32'(sram_addr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_req",   32'(sram_req),   32'd0);
        check_eq("t6_addr",  32'(sram_addr),  32'd0);
        check_eq("t6_wdata", 32'(sram_wdata), 32'd0);
        check_eq("t6_len",   32'(rec_len),    32'd0);
        check_eq("t6_busy",  32'(busy),       32'd0);
        tick();
        rst = 1'b1;
        ticks(2);
        strobe(16'h6363);
        check_eq("t6_idle_req",  32'(sram_req), 32'd0);
        check_eq("t6_idle_busy", 32'(busy),     32'd0);
        ack_mode = 2;
        base = nw;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        strobe(16'h7777);
        ticks(3);
        check_eq("t6_nw", 32'(nw - base), 32'd1);
        check_wr("t6_wr", base, 20'd0, 16'h7777);
        check_eq("t6_len_new", 32'(rec_len), 32'd1);
        pulse_cmd(1'b0, 1'b0, 1'b1);
        wait_done("t6_done", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
